// File: rtl/bcd_to_bin_if.sv
// Request/result handshake bundle for bcd_to_bin.
// master = requester/consumer side, slave = the converter.
interface bcd_to_bin_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [11:0] in_digits;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_err;

  modport master (
    output in_valid, in_sign, in_digits, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  in_valid, in_sign, in_digits, out_ready,
    output in_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/bcd_to_bin.sv
// Serial sign + 3-digit BCD to 8-bit two's-complement converter, one digit per cycle.
// Optional macro BCD_TO_BIN_SATURATE_EN: out-of-range magnitudes saturate instead of flagging.
module bcd_to_bin (
  input logic         clk,
  input logic         rst,
  bcd_to_bin_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic        sign_r;
  logic [11:0] digits_r;
  logic [10:0] acc_r;
  logic        bad_digit_r;
  logic [1:0]  idx_r;
  logic [7:0]  out_data_r;
  logic        out_err_r;
  logic        in_ready_s;
  logic        out_valid_s;
  logic [3:0]  digit_s;
  logic [10:0] acc_next_s;
  logic        bad_next_s;
  logic [7:0]  res_data_s;
  logic        res_err_s;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) state_s = CONV;
        else              state_s = IDLE;
      end
      CONV: begin
        if (idx_r == 2'd0) state_s = DONE;
        else               state_s = CONV;
      end
      DONE: begin
        if (bus.out_ready) state_s = IDLE;
        else               state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Handshake outputs decoded from state only
  always_comb begin
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    case (state_r)
      IDLE:    in_ready_s  = 1'b1;
      DONE:    out_valid_s = 1'b1;
      default: begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
      end
    endcase
  end

  // Digit select (hundreds first) and multiply-by-10 accumulate step
  always_comb begin
    digit_s = 4'd0;
    case (idx_r)
      2'd2:    digit_s = digits_r[11:8];
      2'd1:    digit_s = digits_r[7:4];
      2'd0:    digit_s = digits_r[3:0];
      default: digit_s = 4'd0;
    endcase
    acc_next_s = (acc_r << 3) + (acc_r << 1) + {7'd0, digit_s};
    bad_next_s = bad_digit_r | (digit_s > 4'd9);
  end

  // Final range check and sign application, folded into the units step
  always_comb begin
    res_data_s = 8'd0;
    res_err_s  = 1'b0;
    if (bad_next_s) begin
      res_data_s = 8'd0;
      res_err_s  = 1'b1;
    end else if (!sign_r && (acc_next_s > 11'd127)) begin
`ifdef BCD_TO_BIN_SATURATE_EN
      res_data_s = 8'h7F;
      res_err_s  = 1'b0;
`else
      res_data_s = 8'd0;
      res_err_s  = 1'b1;
`endif
    end else if (sign_r && (acc_next_s > 11'd128)) begin
`ifdef BCD_TO_BIN_SATURATE_EN
      res_data_s = 8'h80;
      res_err_s  = 1'b0;
`else
      res_data_s = 8'd0;
      res_err_s  = 1'b1;
`endif
    end else begin
      res_data_s = sign_r ? (8'd0 - acc_next_s[7:0]) : acc_next_s[7:0];
      res_err_s  = 1'b0;
    end
  end

  // Request capture, accumulator and registered result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_r      <= 1'b0;
      digits_r    <= 12'd0;
      acc_r       <= 11'd0;
      bad_digit_r <= 1'b0;
      idx_r       <= 2'd0;
      out_data_r  <= 8'd0;
      out_err_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            sign_r      <= bus.in_sign;
            digits_r    <= bus.in_digits;
            acc_r       <= 11'd0;
            bad_digit_r <= 1'b0;
            idx_r       <= 2'd2;
          end
        end
        CONV: begin
          acc_r       <= acc_next_s;
          bad_digit_r <= bad_next_s;
          idx_r       <= idx_r - 2'd1;
          if (idx_r == 2'd0) begin
            out_data_r <= res_data_s;
            out_err_r  <= res_err_s;
          end
        end
        default: begin
          acc_r <= acc_r;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.out_data  = out_data_r;
  assign bus.out_err   = out_err_r;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Self-checking bench for bcd_to_bin: directed boundary cases, handshake timing,
// stall, async reset, full round-trip and randomized digits against a decimal model.
module tb_bcd_to_bin;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  bcd_to_bin_if bus ();

  bcd_to_bin dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Decimal reference: value from digit weights, then range/sign rules
  function automatic void ref_model(input logic sgn, input logic [11:0] dig,
                                    output logic [7:0] data, output logic err);
    int h, t, u, mag, v;
    h = int'(dig[11:8]);
    t = int'(dig[7:4]);
    u = int'(dig[3:0]);
    mag = h * 100 + t * 10 + u;
    if (h > 9 || t > 9 || u > 9) begin
      data = 8'd0; err = 1'b1;
    end else if ((!sgn && mag > 127) || (sgn && mag > 128)) begin
`ifdef BCD_TO_BIN_SATURATE_EN
      data = sgn ? 8'h80 : 8'h7F; err = 1'b0;
`else
      data = 8'd0; err = 1'b1;
`endif
    end else begin
      v = sgn ? -mag : mag;
      data = v[7:0]; err = 1'b0;
    end
  endfunction

  // One full transaction; returns observed result, latency and count of busy-time in_ready highs
  task automatic convert(input logic sgn, input logic [11:0] dig,
                         output logic [7:0] data, output logic err,
                         output int lat, output int busy_rdy);
    int guard;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      tick();
      guard++;
    end
    bus.in_valid  = 1'b1;
    bus.in_sign   = sgn;
    bus.in_digits = dig;
    bus.out_ready = 1'b0;
    tick();
    bus.in_valid  = 1'b0;
    bus.in_digits = 12'($urandom);
    bus.in_sign   = 1'($urandom);
    lat = 1;
    busy_rdy = 0;
    while (!bus.out_valid && lat < 20) begin
      if (bus.in_ready) busy_rdy++;
      tick();
      lat++;
    end
    if (bus.in_ready) busy_rdy++;
    data = bus.out_data;
    err  = bus.out_err;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_sign = 1'b0; bus.in_digits = 12'd0; bus.out_ready = 1'b0;
    rst = 1'b1;
    tick(); tick();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got=%h want=00", bus.out_data); end
    checks++; if (bus.out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err got=%b want=0", bus.out_err); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_boundaries();
    logic        sg [9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [11:0] dg [9] = '{12'h127, 12'h128, 12'h000, 12'h128, 12'h255, 12'h129, 12'h0A3, 12'hFFF, 12'h009};
`ifdef BCD_TO_BIN_SATURATE_EN
    logic [7:0]  ed [9] = '{8'h7F, 8'h80, 8'h00, 8'h7F, 8'h80, 8'h80, 8'h00, 8'h00, 8'h09};
    logic        ee [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
`else
    logic [7:0]  ed [9] = '{8'h7F, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h09};
    logic        ee [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`endif
    logic [7:0] d; logic e; int lat, br;
    for (int i = 0; i < 9; i++) begin
      convert(sg[i], dg[i], d, e, lat, br);
      checks++; if (d !== ed[i]) begin errors++; $display("FAIL bound_data case=%0d got=%h want=%h", i, d, ed[i]); end
      checks++; if (e !== ee[i]) begin errors++; $display("FAIL bound_err case=%0d got=%b want=%b", i, e, ee[i]); end
      checks++; if (lat !== 4) begin errors++; $display("FAIL bound_latency case=%0d got=%0d want=4", i, lat); end
      checks++; if (br !== 0) begin errors++; $display("FAIL bound_busy_ready case=%0d got=%0d want=0", i, br); end
    end
  endtask

  task automatic test_back_to_back();
    int c;
    logic exp_rdy, exp_vld;
    while (!bus.in_ready) tick();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_sign   = 1'b0;
    bus.in_digits = 12'h042;
    tick();
    c = 1;
    bus.in_sign   = 1'b1;
    bus.in_digits = 12'h005;
    while (c < 11) begin
      exp_rdy = (c == 5 || c == 10);
      exp_vld = (c == 4 || c == 9);
      checks++; if (bus.in_ready !== exp_rdy) begin errors++; $display("FAIL b2b_in_ready cycle=%0d got=%b want=%b", c, bus.in_ready, exp_rdy); end
      checks++; if (bus.out_valid !== exp_vld) begin errors++; $display("FAIL b2b_out_valid cycle=%0d got=%b want=%b", c, bus.out_valid, exp_vld); end
      if (c == 4) begin
        checks++; if (bus.out_data !== 8'h2A || bus.out_err !== 1'b0) begin errors++; $display("FAIL b2b_first got=%h/%b want=2a/0", bus.out_data, bus.out_err); end
      end
      if (c == 9) begin
        checks++; if (bus.out_data !== 8'hFB || bus.out_err !== 1'b0) begin errors++; $display("FAIL b2b_second got=%h/%b want=fb/0", bus.out_data, bus.out_err); end
        bus.in_valid = 1'b0;
      end
      if (c == 6) begin
        bus.in_sign   = 1'b0;
        bus.in_digits = 12'h999;
      end
      tick();
      c++;
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_stall();
    int lat;
    while (!bus.in_ready) tick();
    bus.in_valid = 1'b1; bus.in_sign = 1'b0; bus.in_digits = 12'h057; bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin tick(); lat++; end
    checks++; if (lat !== 4) begin errors++; $display("FAIL stall_latency got=%0d want=4", lat); end
    bus.in_valid = 1'b1; bus.in_digits = 12'h011; bus.in_sign = 1'b1;
    for (int k = 0; k < 10; k++) begin
      checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_handshake cycle=%0d got vld=%b rdy=%b want vld=1 rdy=0", k, bus.out_valid, bus.in_ready); end
      checks++; if (bus.out_data !== 8'h39 || bus.out_err !== 1'b0) begin errors++; $display("FAIL stall_hold cycle=%0d got=%h/%b want=39/0", k, bus.out_data, bus.out_err); end
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL stall_release got rdy=%b vld=%b want rdy=1 vld=0", bus.in_ready, bus.out_valid); end
    tick();
  endtask

  task automatic test_async_reset();
    logic [7:0] d; logic e; int lat, br;
    while (!bus.in_ready) tick();
    bus.in_valid = 1'b1; bus.in_sign = 1'b1; bus.in_digits = 12'h077;
    tick();
    bus.in_valid = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL areset_handshake got rdy=%b vld=%b want rdy=1 vld=0", bus.in_ready, bus.out_valid); end
    checks++; if (bus.out_data !== 8'h00 || bus.out_err !== 1'b0) begin errors++; $display("FAIL areset_outputs got=%h/%b want=00/0", bus.out_data, bus.out_err); end
    @(negedge clk);
    rst = 1'b0;
    tick(); tick(); tick(); tick(); tick();
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL areset_dropped got vld=%b rdy=%b want vld=0 rdy=1", bus.out_valid, bus.in_ready); end
    convert(1'b0, 12'h099, d, e, lat, br);
    checks++; if (d !== 8'h63 || e !== 1'b0) begin errors++; $display("FAIL areset_fresh got=%h/%b want=63/0", d, e); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL areset_latency got=%0d want=4", lat); end
  endtask

  task automatic test_round_trip();
    logic [7:0] d, want; logic e; int lat, br, mag;
    logic [11:0] dig;
    for (int v = -128; v <= 127; v++) begin
      mag = (v < 0) ? -v : v;
      dig = {4'(mag / 100), 4'((mag / 10) % 10), 4'(mag % 10)};
      want = 8'(v);
      convert(v < 0, dig, d, e, lat, br);
      checks++; if (d !== want || e !== 1'b0) begin errors++; $display("FAIL round_trip value=%0d got=%h/%b want=%h/0", v, d, e, want); end
      checks++; if (lat !== 4 || br !== 0) begin errors++; $display("FAIL round_trip_timing value=%0d got lat=%0d busy_rdy=%0d want 4/0", v, lat, br); end
    end
  endtask

  task automatic test_random();
    logic [7:0] d, ed; logic e, ee, sg; int lat, br;
    logic [11:0] dig;
    for (int i = 0; i < 150; i++) begin
      sg = 1'($urandom);
      for (int j = 0; j < 3; j++) begin
        if ($urandom_range(0, 7) == 0) dig[j*4 +: 4] = 4'($urandom_range(10, 15));
        else if (j == 2)               dig[j*4 +: 4] = 4'($urandom_range(0, 3));
        else                           dig[j*4 +: 4] = 4'($urandom_range(0, 9));
      end
      ref_model(sg, dig, ed, ee);
      convert(sg, dig, d, e, lat, br);
      checks++; if (d !== ed || e !== ee) begin errors++; $display("FAIL random sign=%b digits=%h got=%h/%b want=%h/%b", sg, dig, d, e, ed, ee); end
      checks++; if (lat !== 4) begin errors++; $display("FAIL random_latency digits=%h got=%0d want=4", dig, lat); end
    end
  endtask

  initial begin
    test_reset();
    test_boundaries();
    test_back_to_back();
    test_stall();
    test_async_reset();
    test_round_trip();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bcd_to_bin.md
# bcd_to_bin

Sequential converter from sign-plus-three-digit BCD to 8-bit two's-complement binary; the inverse of the team's binary-to-BCD display path. Sits between decimal entry logic (switches/keypad digit registers) and the complex-multiplier operand registers. It accepts one request per valid/ready handshake and converts with a serial multiply-by-10 accumulate, one digit per cycle. It flags any input that is not a legal signed 8-bit decimal value.

## Interface
- No parameters. Widths are fixed: 3 BCD digits in, 8-bit signed out.
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  request present
- in_ready  out  1  block can accept a request (high only in IDLE)
- in_sign  in  1  1 = negative, 0 = positive
- in_digits  in  12  [11:8] hundreds, [7:4] tens, [3:0] units
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- out_data  out  8  signed two's-complement result
- out_err  out  1  result invalid (bad digit or out of range)

## Operation
- States: IDLE, CONV, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture in_sign and in_digits, clear the 11-bit accumulator acc and the sticky flag bad_digit, set digit index=2, go to CONV.
- CONV:
  - One digit per cycle, in the order hundreds, tens, units: acc <= acc*10 + digit.
  - bad_digit is set if any digit > 9.
  - acc is 11 bits, so worst case 15,15,15 = 1665 does not wrap.
  - After the units step, go to DONE, registering out_data and out_err in the same edge.
- Result rules (base build):
  - bad_digit: out_err=1, out_data=0.
  - Positive with acc > 127, or negative with acc > 128: out_err=1, out_data=0.
  - Otherwise: out_err=0, out_data = in_sign ? -acc[7:0] : acc[7:0].
  - Negative zero gives out_data=0, out_err=0.
  - Negative 128 gives 8'h80.
- DONE:
  - out_valid=1.
  - out_data and out_err are held stable until out_valid&&out_ready, then go to IDLE.
  - in_ready=0, so no new request is accepted in DONE.
- Inputs are sampled only at the accept edge; later in_digits/in_sign changes have no effect.
- Reset (any time, including mid-CONV or in DONE with out_ready low):
  - State IDLE, in_ready=1, out_valid=0, out_data=0, out_err=0, acc=0.
  - An in-flight request is dropped silently.

## Timing
- Accept edge at the end of cycle N. CONV occupies cycles N+1..N+3. out_valid is high from cycle N+4.
- Latency is 4 cycles from accept to out_valid.
- in_ready returns high in the cycle after the output handshake edge.
- Best throughput is one result per 5 cycles (out_ready held high).
- out_ready low stalls indefinitely in DONE, with outputs frozen.
- in_valid is ignored outside IDLE. A requester holding in_valid high is accepted on the first IDLE cycle.
- out_valid, out_data, out_err and in_ready are all registered or state-decoded; there is no combinational path from any input to any output.

## Configuration
- Macro: BCD_TO_BIN_SATURATE_EN.
- Defined:
  - Out-of-range magnitudes saturate: positive gives 127 (8'h7F), negative gives -128 (8'h80), with out_err=0.
  - out_err is set only for bad_digit, and out_data=0 in that case.
  - One extra compare/mux stage is folded into the units step, so latency is unchanged.
- Undefined: the base behaviour under Operation applies.

## Test plan
- Sign=0, digits 1,2,7 -> out_data=8'h7F, out_err=0, out_valid 4 cycles after accept. Sign=1, digits 1,2,8 -> 8'h80, err=0. Sign=1, digits 0,0,0 -> 8'h00, err=0.
- Sign=0, digits 1,2,8 and sign=1, digits 2,5,5:
  - Base build -> 8'h00, err=1.
  - SATURATE_EN -> 8'h7F and 8'h80 respectively, err=0.
- Digits 0,A,3 -> err=1, data=0 in both builds. Digits F,F,F -> no accumulator wrap, err=1.
- Back-to-back requests with out_ready=1:
  - 0,4,2 -> 8'h2A, then sign=1 0,0,5 -> 8'hFB.
  - Check in_ready=0 during CONV/DONE and an exact 5-cycle period.
  - Change in_digits mid-CONV and check the result is unaffected.
- Hold out_ready=0 for 10 cycles in DONE -> out_data/out_err stable, out_valid high, in_ready low, new in_valid ignored. Then pulse out_ready -> IDLE next cycle.
- Assert rst asynchronously mid-CONV (cycle N+2) -> outputs 0 and in_ready=1 immediately. After release, a fresh request 0,9,9 -> 8'h63.
- Round-trip: for all -128..127, a bench model produces the BCD digits, the block converts them, and the result must match the original value with err=0.
